// File: rtl/rv32_fetch_stage_pkg.sv
// Shared fetch-stage types: PC/instruction words, the fetch->decode record and
// the canonical bubble contents.
package rv32_fetch_stage_pkg;

  typedef logic [31:0] rv_pc_t;
  typedef logic [31:0] rv_instr_t;

  localparam rv_instr_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic      valid;
    rv_pc_t    pc;
    rv_instr_t instr;
  } fetch_decode_buffer_t;

  function automatic fetch_decode_buffer_t fd_bubble();
    fetch_decode_buffer_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

  function automatic rv_pc_t align_pc(input rv_pc_t p);
    return p & ~32'h3;
  endfunction

endpackage

// File: rtl/rv32_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface rv32_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/rv32_fetch_stage_fifo.sv
// Small circular buffer with push/pop/flush; used both for the fetched-instruction
// buffer and for the queue of PCs whose responses are still outstanding.
module rv32_fetch_stage_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv32_fetch_stage.sv
// IF stage: owns the PC, issues credit-limited in-order imem requests, drops
// responses made stale by redirects and feeds the registered fetch->decode buffer.
module rv32_fetch_stage
  import rv32_fetch_stage_pkg::*;
#(
  parameter rv_pc_t RESET_PC   = 32'h0000_0000,
  parameter int     FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  rv_pc_t                 redirect_pc,
  rv32_fetch_stage_if.master     imem,
  output fetch_decode_buffer_t   fetch_decode_buff
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rv_pc_t               pc_p0;
  fetch_decode_buffer_t fd_p1;
  logic [CW-1:0]        drop_cnt, in_flight, fifo_count;
  logic                 req, grant, rsp, drop, keep, take, bypass;
  logic                 fifo_push, fifo_pop, fifo_empty, fifo_full, pcq_empty, pcq_full;
  rv_pc_t               pcq_head;
  logic [63:0]          fifo_head;

  // A request needs a guaranteed landing slot: outstanding + buffered must stay below depth.
  assign req = ~rst & ~redirect_valid & ~pcq_full & ~fifo_full &
               (({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
  assign grant = req & imem.imem_gnt;
  assign rsp   = imem.imem_rvalid & ~pcq_empty;
  assign drop  = rsp & (drop_cnt != '0);
  assign keep  = rsp & (drop_cnt == '0);

  assign take      = ~stall & ~redirect_valid;
  assign bypass    = take & fifo_empty & keep;
  assign fifo_pop  = take & ~fifo_empty;
  assign fifo_push = keep & ~redirect_valid & ~bypass;

  assign imem.imem_req   = req;
  assign imem.imem_addr  = pc_p0;
  assign fetch_decode_buff = fd_p1;

  // PC queue count doubles as the in-flight counter; it survives redirects so drops stay aligned.
  rv32_fetch_stage_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (grant),
    .wdata (pc_p0),
    .pop   (rsp),
    .rdata (pcq_head),
    .count (in_flight),
    .empty (pcq_empty),
    .full  (pcq_full)
  );

  rv32_fetch_stage_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push),
    .wdata ({pcq_head, imem.imem_rdata}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // p0: PC and drop bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc_p0    <= align_pc(redirect_pc);
      drop_cnt <= in_flight - CW'(rsp);
    end else begin
      if (grant) pc_p0    <= pc_p0 + 32'd4;
      if (drop)  drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // p1: fetch->decode register; an empty buffer lets a fresh response pass straight through
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      fd_p1 <= fd_bubble();
    end else if (!stall) begin
      if (!fifo_empty)  fd_p1 <= {1'b1, fifo_head};
      else if (keep)    fd_p1 <= {1'b1, pcq_head, imem.imem_rdata};
      else              fd_p1 <= fd_bubble();
    end
  end

endmodule
